// File: rtl/vote_link_arbiter.sv
// Round-robin arbiter sharing one host receive channel among N_PORTS voting terminals.
// Optional host-acknowledge timeout is enabled by defining VOTE_LINK_TIMEOUT_EN.
module vote_link_arbiter #(
   parameter int N_PORTS = 4,
   parameter int DATA_W  = 4,
   parameter int TIMEOUT = 15
) (
   input  logic                        CLOCK,
   input  logic                        RESET,
   input  logic [N_PORTS-1:0]          RTS,
   input  logic [N_PORTS*DATA_W-1:0]   V_OUT,
   output logic [N_PORTS-1:0]          CTS,
   output logic                        HOST_RTS,
   output logic [DATA_W-1:0]           HOST_DATA,
   input  logic                        HOST_CTR,
   output logic [2:0]                  GRANT_ID,
   output logic                        BUSY,
   output logic                        ERR,
   output logic [7:0]                  XFER_CNT
);

   if (N_PORTS < 2 || N_PORTS > 8 || TIMEOUT < 1) begin : g_param_check
      $error("vote_link_arbiter: N_PORTS must be 2..8 and TIMEOUT at least 1");
   end

   typedef enum logic [1:0] {IDLE, SEND, ACK, RELEASE} state_t;

   state_t               state_q, state_d;
   logic [2:0]           ptr_q, ptr_d;
   logic [2:0]           grant_q, grant_d;
   logic                 host_rts_q, host_rts_d;
   logic [DATA_W-1:0]    host_data_q, host_data_d;
   logic [N_PORTS-1:0]   cts_q, cts_d;
   logic                 err_q, err_d;
   logic [7:0]           xfer_q, xfer_d;

`ifdef VOTE_LINK_TIMEOUT_EN
   localparam int CW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
   logic [CW-1:0]        tmo_q, tmo_d;
`endif

   logic                 req_found;
   logic [2:0]           req_idx;
   logic [DATA_W-1:0]    req_data;
   logic                 rts_k;
   logic [N_PORTS-1:0]   grant_oh;
   logic [2:0]           ptr_after;

   // Search order starts at ptr and wraps modulo N_PORTS.
   always_comb begin
      req_found = 1'b0;
      req_idx   = 3'd0;
      for (int i = 0; i < N_PORTS; i++) begin
         for (int p = 0; p < N_PORTS; p++) begin
            if (!req_found && RTS[p] && (((int'(ptr_q) + i) % N_PORTS) == p)) begin
               req_found = 1'b1;
               req_idx   = 3'(p);
            end
         end
      end
   end

   always_comb begin
      req_data = '0;
      rts_k    = 1'b0;
      grant_oh = '0;
      for (int p = 0; p < N_PORTS; p++) begin
         if (req_idx == 3'(p)) req_data = V_OUT[p*DATA_W +: DATA_W];
         if (grant_q == 3'(p)) begin
            rts_k       = RTS[p];
            grant_oh[p] = 1'b1;
         end
      end
      ptr_after = (int'(grant_q) == N_PORTS - 1) ? 3'd0 : grant_q + 3'd1;
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      grant_d     = grant_q;
      host_rts_d  = host_rts_q;
      host_data_d = host_data_q;
      cts_d       = cts_q;
      err_d       = err_q;
      xfer_d      = xfer_q;
`ifdef VOTE_LINK_TIMEOUT_EN
      tmo_d       = tmo_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (req_found) begin
               host_data_d = req_data;
               grant_d     = req_idx;
               host_rts_d  = 1'b1;
               state_d     = SEND;
`ifdef VOTE_LINK_TIMEOUT_EN
               tmo_d       = '0;
`endif
            end
         end
         SEND: begin
            // An acknowledge in the same cycle as a withdrawal still counts as an acknowledge.
            if (HOST_CTR) begin
               host_rts_d = 1'b0;
               cts_d      = grant_oh;
               state_d    = ACK;
            end else if (!rts_k) begin
               host_rts_d = 1'b0;
               err_d      = 1'b1;
               state_d    = RELEASE;
`ifdef VOTE_LINK_TIMEOUT_EN
            end else if (tmo_q == CW'(TIMEOUT - 1)) begin
               host_rts_d = 1'b0;
               err_d      = 1'b1;
               ptr_d      = ptr_after;
               state_d    = RELEASE;
            end else begin
               tmo_d      = tmo_q + 1'b1;
`endif
            end
         end
         ACK: begin
            if (!rts_k && !HOST_CTR) begin
               cts_d   = '0;
               ptr_d   = ptr_after;
               xfer_d  = xfer_q + 8'd1;
               state_d = IDLE;
            end
         end
         RELEASE: begin
            if (!HOST_CTR) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q     <= IDLE;
         ptr_q       <= 3'd0;
         grant_q     <= 3'd0;
         host_rts_q  <= 1'b0;
         host_data_q <= '0;
         cts_q       <= '0;
         err_q       <= 1'b0;
         xfer_q      <= 8'd0;
`ifdef VOTE_LINK_TIMEOUT_EN
         tmo_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         grant_q     <= grant_d;
         host_rts_q  <= host_rts_d;
         host_data_q <= host_data_d;
         cts_q       <= cts_d;
         err_q       <= err_d;
         xfer_q      <= xfer_d;
`ifdef VOTE_LINK_TIMEOUT_EN
         tmo_q       <= tmo_d;
`endif
      end
   end

   assign CTS       = cts_q;
   assign HOST_RTS  = host_rts_q;
   assign HOST_DATA = host_data_q;
   assign GRANT_ID  = grant_q;
   assign BUSY      = (state_q != IDLE);
   assign ERR       = err_q;
   assign XFER_CNT  = xfer_q;

endmodule

// File: tb/tb_vote_link_arbiter.sv
// Directed bench for vote_link_arbiter: a per-cycle vector table plus hand-written sequences.
// The timeout sequence is built only when VOTE_LINK_TIMEOUT_EN is defined.
module tb_vote_link_arbiter;

   logic        CLOCK = 1'b0;
   logic        RESET;
   logic [3:0]  RTS;
   logic [15:0] V_OUT;
   logic [3:0]  CTS;
   logic        HOST_RTS;
   logic [3:0]  HOST_DATA;
   logic        HOST_CTR;
   logic [2:0]  GRANT_ID;
   logic        BUSY;
   logic        ERR;
   logic [7:0]  XFER_CNT;

   int passed = 0;
   int total  = 0;

   vote_link_arbiter #(.N_PORTS(4), .DATA_W(4), .TIMEOUT(15)) dut (
      .CLOCK(CLOCK), .RESET(RESET), .RTS(RTS), .V_OUT(V_OUT), .CTS(CTS),
      .HOST_RTS(HOST_RTS), .HOST_DATA(HOST_DATA), .HOST_CTR(HOST_CTR),
      .GRANT_ID(GRANT_ID), .BUSY(BUSY), .ERR(ERR), .XFER_CNT(XFER_CNT)
   );

   always #5 CLOCK = ~CLOCK;

   typedef struct {
      logic [3:0] rts;
      logic       ctr;
      logic [3:0] cts;
      logic       hrts;
      logic [3:0] hdata;
      logic [2:0] gid;
      logic       busy;
      logic       err;
      logic [7:0] xfer;
   } vec_t;

   vec_t tbl [21];

   task automatic step();
      @(posedge CLOCK);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else
         passed++;
   endtask

   task automatic chk_all(input string tag, input logic [3:0] cts, input logic hrts,
                          input logic [3:0] hdata, input logic [2:0] gid, input logic busy,
                          input logic err, input logic [7:0] xfer);
      chk({tag, " CTS"},       32'(CTS),       32'(cts));
      chk({tag, " HOST_RTS"},  32'(HOST_RTS),  32'(hrts));
      chk({tag, " HOST_DATA"}, 32'(HOST_DATA), 32'(hdata));
      chk({tag, " GRANT_ID"},  32'(GRANT_ID),  32'(gid));
      chk({tag, " BUSY"},      32'(BUSY),      32'(busy));
      chk({tag, " ERR"},       32'(ERR),       32'(err));
      chk({tag, " XFER_CNT"},  32'(XFER_CNT),  32'(xfer));
   endtask

   initial begin
      // Port words: p3=5, p2=A, p1=3, p0=C
      V_OUT    = 16'h5A3C;
      RESET    = 1'b1;
      RTS      = 4'b0000;
      HOST_CTR = 1'b0;

      //                rts      ctr   cts      hrts  data   gid   busy  err   xfer
      tbl[0]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 8'd0};
      tbl[1]  = '{4'b0100, 1'b0, 4'b0000, 1'b1, 4'hA, 3'd2, 1'b1, 1'b0, 8'd0};
      tbl[2]  = '{4'b0100, 1'b0, 4'b0000, 1'b1, 4'hA, 3'd2, 1'b1, 1'b0, 8'd0};
      tbl[3]  = '{4'b0100, 1'b1, 4'b0100, 1'b0, 4'hA, 3'd2, 1'b1, 1'b0, 8'd0};
      tbl[4]  = '{4'b0000, 1'b1, 4'b0100, 1'b0, 4'hA, 3'd2, 1'b1, 1'b0, 8'd0};
      tbl[5]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'hA, 3'd2, 1'b0, 1'b0, 8'd1};
      tbl[6]  = '{4'b1011, 1'b0, 4'b0000, 1'b1, 4'h5, 3'd3, 1'b1, 1'b0, 8'd1};
      tbl[7]  = '{4'b1011, 1'b1, 4'b1000, 1'b0, 4'h5, 3'd3, 1'b1, 1'b0, 8'd1};
      tbl[8]  = '{4'b0011, 1'b0, 4'b0000, 1'b0, 4'h5, 3'd3, 1'b0, 1'b0, 8'd2};
      tbl[9]  = '{4'b0011, 1'b0, 4'b0000, 1'b1, 4'hC, 3'd0, 1'b1, 1'b0, 8'd2};
      tbl[10] = '{4'b0010, 1'b0, 4'b0000, 1'b0, 4'hC, 3'd0, 1'b1, 1'b1, 8'd2};
      tbl[11] = '{4'b0010, 1'b0, 4'b0000, 1'b0, 4'hC, 3'd0, 1'b0, 1'b1, 8'd2};
      tbl[12] = '{4'b0010, 1'b0, 4'b0000, 1'b1, 4'h3, 3'd1, 1'b1, 1'b1, 8'd2};
      tbl[13] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'h3, 3'd1, 1'b1, 1'b1, 8'd2};
      tbl[14] = '{4'b0110, 1'b0, 4'b0000, 1'b0, 4'h3, 3'd1, 1'b0, 1'b1, 8'd2};
      tbl[15] = '{4'b0110, 1'b0, 4'b0000, 1'b1, 4'h3, 3'd1, 1'b1, 1'b1, 8'd2};
      tbl[16] = '{4'b0100, 1'b1, 4'b0010, 1'b0, 4'h3, 3'd1, 1'b1, 1'b1, 8'd2};
      tbl[17] = '{4'b0100, 1'b0, 4'b0000, 1'b0, 4'h3, 3'd1, 1'b0, 1'b1, 8'd3};
      tbl[18] = '{4'b0100, 1'b0, 4'b0000, 1'b1, 4'hA, 3'd2, 1'b1, 1'b1, 8'd3};
      tbl[19] = '{4'b0100, 1'b1, 4'b0100, 1'b0, 4'hA, 3'd2, 1'b1, 1'b1, 8'd3};
      tbl[20] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'hA, 3'd2, 1'b0, 1'b1, 8'd4};

      step();
      step();
      chk_all("reset", 4'b0000, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 8'd0);
      RESET = 1'b0;

      for (int r = 0; r < 21; r++) begin
         RTS      = tbl[r].rts;
         HOST_CTR = tbl[r].ctr;
         step();
         chk_all($sformatf("row%0d", r), tbl[r].cts, tbl[r].hrts, tbl[r].hdata,
                 tbl[r].gid, tbl[r].busy, tbl[r].err, tbl[r].xfer);
      end

      // Mid-transfer reset while CTS[3] is asserted (ptr is 3 here).
      RTS = 4'b1000; HOST_CTR = 1'b0;
      step();
      chk("midrst grant", 32'(GRANT_ID), 32'd3);
      HOST_CTR = 1'b1;
      step();
      chk("midrst CTS before", 32'(CTS), 32'b1000);
      RESET = 1'b1;
      step();
      chk_all("midrst", 4'b0000, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 8'd0);
      RESET = 1'b0; RTS = 4'b0000; HOST_CTR = 1'b0;
      step();

      // Round-robin with all four requesting; each port drops only its own RTS to finish.
      for (int n = 0; n < 5; n++) begin
         int k;
         k = n % 4;
         RTS = 4'b1111; HOST_CTR = 1'b0;
         step();
         chk($sformatf("rr%0d grant", n), 32'(GRANT_ID), 32'(k));
         chk($sformatf("rr%0d HOST_RTS", n), 32'(HOST_RTS), 32'd1);
         HOST_CTR = 1'b1;
         step();
         chk($sformatf("rr%0d CTS", n), 32'(CTS), 32'(1 << k));
         RTS = 4'b1111 & ~(4'b0001 << k); HOST_CTR = 1'b0;
         step();
         chk($sformatf("rr%0d XFER_CNT", n), 32'(XFER_CNT), 32'(n + 1));
      end

`ifndef VOTE_LINK_TIMEOUT_EN
      // Without the timeout, SEND holds for as long as the host stays silent.
      RTS = 4'b0010; HOST_CTR = 1'b0;
      step();
      chk("hold grant", 32'(GRANT_ID), 32'd1);
      repeat (20) step();
      chk("hold HOST_RTS", 32'(HOST_RTS), 32'd1);
      chk("hold ERR", 32'(ERR), 32'd0);
      HOST_CTR = 1'b1;
      step();
      RTS = 4'b0000; HOST_CTR = 1'b0;
      step();
      chk("hold XFER_CNT", 32'(XFER_CNT), 32'd6);
`endif

      // Counter wrap after 256 completed transfers.
      RESET = 1'b1; RTS = 4'b0000; HOST_CTR = 1'b0;
      step();
      RESET = 1'b0;
      for (int n = 0; n < 256; n++) begin
         RTS = 4'b0001; HOST_CTR = 1'b0;
         step();
         HOST_CTR = 1'b1;
         step();
         RTS = 4'b0000; HOST_CTR = 1'b0;
         step();
         if (n == 254) chk("wrap 255", 32'(XFER_CNT), 32'd255);
      end
      chk("wrap XFER_CNT", 32'(XFER_CNT), 32'd0);
      chk("wrap ERR", 32'(ERR), 32'd0);

`ifdef VOTE_LINK_TIMEOUT_EN
      // Host never acknowledges: 15 SEND cycles, then release and move on.
      RESET = 1'b1;
      step();
      RESET = 1'b0; RTS = 4'b0011; HOST_CTR = 1'b0;
      step();
      chk("tmo grant", 32'(GRANT_ID), 32'd0);
      repeat (14) step();
      chk("tmo HOST_RTS at 14", 32'(HOST_RTS), 32'd1);
      chk("tmo ERR at 14", 32'(ERR), 32'd0);
      step();
      chk("tmo HOST_RTS at 15", 32'(HOST_RTS), 32'd0);
      chk("tmo ERR at 15", 32'(ERR), 32'd1);
      step();
      chk("tmo BUSY idle", 32'(BUSY), 32'd0);
      step();
      chk("tmo next grant", 32'(GRANT_ID), 32'd1);
      chk("tmo next HOST_RTS", 32'(HOST_RTS), 32'd1);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
